// File: rtl/snn_pkg.sv
// snn_pkg: shared sparse-word layout and encoder state type for the synaptic input stream.
package snn_pkg;
  localparam int SPARSE_SLOTS    = 3;
  localparam int SLOT_W          = 8;
  localparam int SPARSE_LAST_BIT = 31;
  typedef enum logic {IDLE, EMIT} enc_state_t;
  typedef struct packed {
    logic                                   last;
    logic [SPARSE_LAST_BIT-SPARSE_SLOTS*SLOT_W-1:0] rsvd;
    logic [SPARSE_SLOTS-1:0][SLOT_W-1:0]    slots;
  } sparse_word_t;
endpackage

// File: rtl/sparse_slot_packer.sv
// sparse_slot_packer: picks the three lowest set bits of a mask, packs them as {v, idx} slots and clears them.
module sparse_slot_packer
  import snn_pkg::*;
#(
  parameter int DEEPTH = 128,
  parameter int IDXWID = $clog2(DEEPTH)
) (
  input  logic [DEEPTH-1:0]                    mask,
  output logic [SPARSE_SLOTS-1:0][SLOT_W-1:0]  slots,
  output logic [DEEPTH-1:0]                    cleared,
  output logic [1:0]                           count
);
  logic [IDXWID-1:0] idx;
  always_comb begin
    slots   = '0;
    cleared = mask;
    count   = '0;
    idx     = '0;
    for (int k = 0; k < SPARSE_SLOTS; k++) begin
      idx = '0;
      for (int i = DEEPTH - 1; i >= 0; i--) idx = cleared[i] ? IDXWID'(i) : idx;
      if (|cleared) begin
        slots[k] = {1'b1, 7'(idx)};
        count    = count + 2'd1;
      end
      cleared = cleared & (cleared - DEEPTH'(1));
    end
  end
endmodule

// File: rtl/spike_sparse_encoder.sv
// spike_sparse_encoder: splits a dense spike vector into two channels of 32-bit sparse words.
// Optional SPIKE_ENC_STATS_EN adds frame_cnt / spike_cnt counters.
module spike_sparse_encoder
  import snn_pkg::*;
#(
  parameter int DEEPTH = 128,
  parameter int IDXWID = $clog2(DEEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                spk_valid,
  output logic                spk_ready,
  input  logic [2*DEEPTH-1:0] spk_vec,
  output logic                sparse_valid0,
  output logic                sparse_valid1,
  input  logic                sparse_ready0,
  input  logic                sparse_ready1,
  output logic [31:0]         sparse_bits0,
  output logic [31:0]         sparse_bits1
`ifdef SPIKE_ENC_STATS_EN
  ,
  output logic [15:0]         frame_cnt,
  output logic [23:0]         spike_cnt
`endif
);
  logic [1:0] idle, vld, rdy, hs;
  logic [1:0][SPARSE_SLOTS-1:0] vbits;
  logic [1:0][31:0] bits;
  logic accept;
  assign spk_ready     = &idle;
  assign accept        = spk_valid && spk_ready;
  assign rdy           = {sparse_ready1, sparse_ready0};
  assign hs            = vld & rdy;
  assign sparse_valid0 = vld[0];
  assign sparse_valid1 = vld[1];
  assign sparse_bits0  = bits[0];
  assign sparse_bits1  = bits[1];
  for (genvar c = 0; c < 2; c++) begin : g_ch
    enc_state_t state;
    sparse_word_t word;
    logic valid;
    logic [DEEPTH-1:0] rem, src, clr;
    logic [SPARSE_SLOTS-1:0][SLOT_W-1:0] slots;
    logic [1:0] cnt;
    assign src = state == IDLE ? spk_vec[c*DEEPTH +: DEEPTH] : rem;
    sparse_slot_packer #(.DEEPTH(DEEPTH), .IDXWID(IDXWID)) u_pack (
      .mask(src), .slots(slots), .cleared(clr), .count(cnt)
    );
    assign idle[c] = state == IDLE;
    assign vld[c]  = valid;
    assign bits[c] = word;
    for (genvar k = 0; k < SPARSE_SLOTS; k++) begin : g_v
      assign vbits[c][k] = word.slots[k][SLOT_W-1];
    end
    // a short pick means the mask ran dry, so last is known without waiting on the clear
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        rem   <= '0;
        word  <= '0;
        valid <= 1'b0;
      end else if (state == IDLE ? accept : hs[c] && !word.last) begin
        state      <= EMIT;
        valid      <= 1'b1;
        rem        <= clr;
        word.last  <= cnt != 2'(SPARSE_SLOTS) || !(|clr);
        word.rsvd  <= '0;
        word.slots <= slots;
      end else if (hs[c]) begin
        state <= IDLE;
        valid <= 1'b0;
      end
    end
  end
`ifdef SPIKE_ENC_STATS_EN
  logic [2:0] add;
  always_comb begin
    add = '0;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < SPARSE_SLOTS; k++) add = add + 3'(hs[c] & vbits[c][k]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      spike_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 16'(accept);
      spike_cnt <= spike_cnt + 24'(add);
    end
  end
`endif
endmodule

// File: tb/tb_spike_sparse_encoder.sv
// tb_spike_sparse_encoder: directed + random vectors checked against a queue-based word model.
module tb_spike_sparse_encoder;
  localparam int D = 128;
  logic clk = 0, rst_n = 0, spk_valid = 0, spk_ready;
  logic sparse_ready0 = 1, sparse_ready1 = 1, sparse_valid0, sparse_valid1;
  logic [2*D-1:0] spk_vec = '0;
  logic [31:0] sparse_bits0, sparse_bits1;
`ifdef SPIKE_ENC_STATS_EN
  logic [15:0] frame_cnt;
  logic [23:0] spike_cnt;
`endif
  int n_vec = 0, n_bad = 0, exp_frames = 0, exp_spikes = 0, n_hs0 = 0;
  bit rnd = 0, hold0 = 0, hold1 = 0;
  logic [31:0] hb0, hb1, last0;
  logic [31:0] exp0[$], exp1[$];

  always #5 clk = ~clk;

  spike_sparse_encoder #(.DEEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_vec(spk_vec),
    .sparse_valid0(sparse_valid0), .sparse_valid1(sparse_valid1),
    .sparse_ready0(sparse_ready0), .sparse_ready1(sparse_ready1),
    .sparse_bits0(sparse_bits0), .sparse_bits1(sparse_bits1)
`ifdef SPIKE_ENC_STATS_EN
    , .frame_cnt(frame_cnt), .spike_cnt(spike_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void push(input int c, input logic [31:0] w);
    if (c == 0) exp0.push_back(w);
    else exp1.push_back(w);
  endfunction

  // reference: list set indices, chunk them by three, flag the final chunk
  function automatic void model(input logic [2*D-1:0] v);
    int idx[$];
    logic [31:0] w;
    for (int c = 0; c < 2; c++) begin
      idx.delete();
      for (int i = 0; i < D; i++) if (v[c*D+i]) idx.push_back(i);
      exp_spikes += idx.size();
      if (idx.size() == 0) push(c, 32'h8000_0000);
      for (int j = 0; j < idx.size(); j += 3) begin
        w = '0;
        for (int k = 0; k < 3; k++) if (j + k < idx.size()) w[8*k +: 8] = 8'h80 | 8'(idx[j+k]);
        w[31] = (j + 3 >= idx.size());
        push(c, w);
      end
    end
    exp_frames++;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      hold0 = 0;
      hold1 = 0;
    end else begin
      if (hold0) chk("hold0", {sparse_valid0, sparse_bits0}, {1'b1, hb0});
      if (hold1) chk("hold1", {sparse_valid1, sparse_bits1}, {1'b1, hb1});
      if (sparse_valid0 && sparse_ready0) begin
        n_hs0++;
        last0 = sparse_bits0;
        chk("q0_nonempty", exp0.size() != 0, 1);
        if (exp0.size() != 0) chk("word0", sparse_bits0, exp0.pop_front());
      end
      if (sparse_valid1 && sparse_ready1) begin
        chk("q1_nonempty", exp1.size() != 0, 1);
        if (exp1.size() != 0) chk("word1", sparse_bits1, exp1.pop_front());
      end
      hold0 = sparse_valid0 && !sparse_ready0;
      hold1 = sparse_valid1 && !sparse_ready1;
      hb0 = sparse_bits0;
      hb1 = sparse_bits1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) begin
      sparse_ready0 = 1'($urandom_range(0, 1));
      sparse_ready1 = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send(input logic [2*D-1:0] v);
    spk_vec = v;
    spk_valid = 1;
    for (int t = 0; t < 2000 && !spk_ready; t++) tick();
    chk("spk_ready_wait", spk_ready, 1);
    if (spk_ready) begin
      model(v);
      tick();
      chk("first_valid", {spk_ready, sparse_valid0, sparse_valid1}, 3'b011);
    end
    spk_valid = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 5000 && !(spk_ready && exp0.size() == 0 && exp1.size() == 0); t++) tick();
    chk("drain", {spk_ready, exp0.size() == 0, exp1.size() == 0}, 3'b111);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [2*D-1:0] v;
    int h;
    tick();
    tick();
    chk("reset_state", {spk_ready, sparse_valid0, sparse_valid1, sparse_bits0, sparse_bits1}, {3'b100, 64'h0});
    rst_n = 1;
    tick();
`ifdef SPIKE_ENC_STATS_EN
    send({128'h5, 128'h3});
    send('0);
    send({128'h70, 128'hF});
    drain();
    chk("frame_cnt3", frame_cnt, 3);
    chk("spike_cnt11", spike_cnt, 11);
`endif
    v = '0;
    v[0] = 1; v[5] = 1; v[9] = 1; v[100] = 1;
    send(v);
    chk("t1_word0", sparse_bits0, 32'h0089_8580);
    chk("t1_word1", sparse_bits1, 32'h8000_0000);
    tick();
    chk("t1_busy", {spk_ready, sparse_bits0}, {1'b0, 32'h8000_00E4});
    tick();
    chk("t1_ready_back", spk_ready, 1);
    send('0);
    chk("zero_ch0", {sparse_bits0, sparse_bits1}, {32'h8000_0000, 32'h8000_0000});
    drain();
    h = n_hs0;
    send({128'h0, {128{1'b1}}});
    drain();
    chk("all128_words", n_hs0 - h, 43);
    chk("all128_last", last0, 32'h8000_FFFE);
    v = '0;
    for (int i = 0; i < 30; i++) v[i*4] = 1;
    send(v);
    tick();
    tick();
    sparse_ready0 = 0;
    tick();
    hb0 = sparse_bits0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stable", {sparse_valid0, sparse_bits0}, {1'b1, hb0});
    end
    sparse_ready0 = 1;
    drain();
    v = '0;
    for (int i = 0; i < 10; i++) v[D + 3*i + 1] = 1;
    send(v);
    sparse_ready1 = 0;
    spk_vec = {128'h1, 128'h2};
    spk_valid = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("spk_ready_blocked", spk_ready, 0);
    end
    sparse_ready1 = 1;
    send({128'h1, 128'h2});
    drain();
    send({{128{1'b1}}, {128{1'b1}}});
    tick();
    #2 rst_n = 0;
    #1 chk("async_reset", {spk_ready, sparse_valid0, sparse_valid1, sparse_bits0, sparse_bits1}, {3'b100, 64'h0});
    exp0.delete();
    exp1.delete();
    exp_spikes = 0;
    exp_frames = 0;
    tick();
    rst_n = 1;
    tick();
    send({128'h8001, 128'h7});
    drain();
    rnd = 1;
    for (int n = 0; n < 30; n++) begin
      for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom & $urandom & ((n % 3 == 0) ? 32'hFFFF_FFFF : $urandom);
      if (n % 7 == 3) v = '0;
      send(v);
      if (n % 5 == 4) drain();
    end
    rnd = 0;
    sparse_ready0 = 1;
    sparse_ready1 = 1;
    drain();
`ifdef SPIKE_ENC_STATS_EN
    chk("frame_cnt_end", frame_cnt, 16'(exp_frames));
    chk("spike_cnt_end", spike_cnt, 24'(exp_spikes));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
